// File: rtl/par3_to_ser.sv
// Triple-to-serial converter: buffers parallel sample triples in a small FIFO
// and emits them one word per accepted cycle under a valid/ready handshake.
module par3_to_ser #(
   parameter int WIDTH = 11,
   parameter int DEPTH = 4
) (
   input  logic                     CLK,
   input  logic                     RST_n,
   input  logic                     VIN,
   input  logic [WIDTH-1:0]         DIN3k,
   input  logic [WIDTH-1:0]         DIN3k1,
   input  logic [WIDTH-1:0]         DIN3k2,
   input  logic                     READY,
   output logic [WIDTH-1:0]         DOUT,
   output logic                     VOUT,
   output logic [$clog2(DEPTH):0]   LEVEL,
   output logic                     OVF
);

   localparam int AW = $clog2(DEPTH);

   logic [3*WIDTH-1:0] mem [DEPTH];
   logic [3*WIDTH-1:0] head;

   logic [AW-1:0] rd_ptr, rd_nxt;
   logic [AW-1:0] wr_ptr, wr_nxt;
   logic [AW:0]   level, level_nxt;
   logic [1:0]    phase, phase_nxt;
   logic          ovf, ovf_nxt;

   logic          full, xfer, pop, wr;

   // state register
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         level  <= '0;
         phase  <= '0;
         ovf    <= 1'b0;
      end else begin
         rd_ptr <= rd_nxt;
         wr_ptr <= wr_nxt;
         level  <= level_nxt;
         phase  <= phase_nxt;
         ovf    <= ovf_nxt;
      end
   end

   // a pop frees the full slot on the same edge, so a write may still land
   always_comb begin
      full      = (level == (AW+1)'(DEPTH));
      xfer      = (level != '0) && READY;
      pop       = xfer && (phase == 2'd2);
      wr        = VIN && (!full || pop);
      rd_nxt    = pop ? rd_ptr + AW'(1) : rd_ptr;
      wr_nxt    = wr ? wr_ptr + AW'(1) : wr_ptr;
      level_nxt = level + (AW+1)'(wr) - (AW+1)'(pop);
      ovf_nxt   = ovf || (VIN && !wr);
      phase_nxt = phase;
      if (pop)
         phase_nxt = 2'd0;
      else if (xfer)
         phase_nxt = phase + 2'd1;
   end

   // data array carries no reset; DOUT is masked while empty
   always_ff @(posedge CLK) begin
      if (wr && RST_n)
         mem[wr_ptr] <= {DIN3k2, DIN3k1, DIN3k};
   end

   always_comb begin
      head  = mem[rd_ptr];
      VOUT  = (level != '0);
      LEVEL = level;
      OVF   = ovf;
      DOUT  = '0;
      if (VOUT) begin
         unique case (phase)
            2'd0:    DOUT = head[WIDTH-1:0];
            2'd1:    DOUT = head[2*WIDTH-1:WIDTH];
            2'd2:    DOUT = head[3*WIDTH-1:2*WIDTH];
            default: DOUT = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_par3_to_ser.sv
// Bench for par3_to_ser: directed scenarios plus randomized traffic
// checked against a queue-based model of the triple FIFO.
module tb_par3_to_ser;

   localparam int W = 11;
   localparam int D = 4;

   logic         CLK = 1'b0;
   logic         RST_n;
   logic         VIN;
   logic [W-1:0] DIN3k, DIN3k1, DIN3k2;
   logic         READY;
   logic [W-1:0] DOUT;
   logic         VOUT;
   logic [2:0]   LEVEL;
   logic         OVF;

   int errs = 0;
   int checks = 0;

   logic [3*W-1:0] mq[$];
   int             mph;
   bit             movf;
   logic [W-1:0]   mexp[$];
   logic [W-1:0]   got[$];

   par3_to_ser #(.WIDTH(W), .DEPTH(D)) dut (
      .CLK(CLK), .RST_n(RST_n), .VIN(VIN),
      .DIN3k(DIN3k), .DIN3k1(DIN3k1), .DIN3k2(DIN3k2),
      .READY(READY), .DOUT(DOUT), .VOUT(VOUT),
      .LEVEL(LEVEL), .OVF(OVF)
   );

   always #5 CLK = ~CLK;

   function automatic logic [W-1:0] m_dout();
      logic [3*W-1:0] t;
      if (mq.size() == 0) return '0;
      t = mq[0];
      return t[mph*W +: W];
   endfunction

   function automatic void m_clear();
      mq.delete();
      mexp.delete();
      got.delete();
      mph = 0;
      movf = 0;
   endfunction

   // one clock: inputs applied 1 time unit after an edge, outputs settled by then
   task automatic step(input bit v, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] c,
                       input bit r);
      bit mv, mx, mp, acc;
      VIN = v; DIN3k = a; DIN3k1 = b; DIN3k2 = c; READY = r;
      if (VOUT && r) got.push_back(DOUT);
      mv  = mq.size() > 0;
      mx  = mv && r;
      mp  = mx && (mph == 2);
      acc = v && (mq.size() < D || mp);
      if (mx) begin
         mexp.push_back(m_dout());
         if (mph == 2) begin
            mph = 0;
            void'(mq.pop_front());
         end else mph++;
      end
      if (v) begin
         if (acc) mq.push_back({c, b, a});
         else movf = 1;
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RST_n = 1'b0;
      VIN = 1'b0; READY = 1'b0;
      @(posedge CLK);
      #1;
      RST_n = 1'b1;
      m_clear();
   endtask

   task automatic test_reset();
      RST_n = 1'b0; VIN = 1'b1; READY = 1'b1;
      DIN3k = 11'd9; DIN3k1 = 11'd8; DIN3k2 = 11'd7;
      #1;
      checks++;
      if (VOUT !== 1'b0 || DOUT !== '0 || LEVEL !== 3'd0 || OVF !== 1'b0) begin
         errs++;
         $display("FAIL reset_state: vout=%b dout=%0d level=%0d ovf=%b want 0", VOUT, DOUT, LEVEL, OVF);
      end
      @(posedge CLK);
      #1;
      checks++;
      if (VOUT !== 1'b0 || LEVEL !== 3'd0) begin
         errs++;
         $display("FAIL reset_vin_ignored: vout=%b level=%0d want 0 0", VOUT, LEVEL);
      end
      RST_n = 1'b1; VIN = 1'b0;
      m_clear();
   endtask

   task automatic test_single();
      logic [W-1:0] want [3];
      want[0] = W'(5); want[1] = W'(-3); want[2] = W'(7);
      do_reset();
      step(1, want[0], want[1], want[2], 1);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (VOUT !== 1'b1 || DOUT !== want[i] || LEVEL !== 3'd1) begin
            errs++;
            $display("FAIL single_word%0d: vout=%b dout=%0d level=%0d want 1 %0d 1", i, VOUT, DOUT, LEVEL, want[i]);
         end
         step(0, '0, '0, '0, 1);
      end
      checks++;
      if (VOUT !== 1'b0 || DOUT !== '0 || LEVEL !== 3'd0 || OVF !== 1'b0) begin
         errs++;
         $display("FAIL single_end: vout=%b dout=%0d level=%0d ovf=%b want 0 0 0 0", VOUT, DOUT, LEVEL, OVF);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      step(1, W'(1), W'(2), W'(3), 0);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (VOUT !== 1'b1 || DOUT !== W'(1)) begin
            errs++;
            $display("FAIL bp_hold%0d: vout=%b dout=%0d want 1 1", i, VOUT, DOUT);
         end
         step(0, '0, '0, '0, 0);
      end
      for (int i = 0; i < 5; i++) step(0, '0, '0, '0, 1);
      checks++;
      if (got.size() != 3 || got[0] !== W'(1) || got[1] !== W'(2) || got[2] !== W'(3)) begin
         errs++;
         $display("FAIL bp_words: got %p want 1 2 3", got);
      end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < 5; i++)
         step(1, W'(10*i), W'(10*i+1), W'(10*i+2), 0);
      checks++;
      if (LEVEL !== 3'd4 || OVF !== 1'b1) begin
         errs++;
         $display("FAIL ovf_full: level=%0d ovf=%b want 4 1", LEVEL, OVF);
      end
      for (int i = 0; i < 16; i++) step(0, '0, '0, '0, 1);
      checks++;
      if (got.size() != 12) begin
         errs++;
         $display("FAIL ovf_count: got %0d words want 12", got.size());
      end
      for (int i = 0; i < 12 && i < got.size(); i++) begin
         checks++;
         if (got[i] !== W'(10*(i/3) + i%3)) begin
            errs++;
            $display("FAIL ovf_word%0d: got %0d want %0d", i, got[i], 10*(i/3) + i%3);
         end
      end
      checks++;
      if (OVF !== 1'b1) begin
         errs++;
         $display("FAIL ovf_sticky: ovf=%b want 1", OVF);
      end
   endtask

   task automatic test_full_pop();
      do_reset();
      for (int i = 0; i < 4; i++) step(1, W'(i), W'(i), W'(i), 0);
      step(0, '0, '0, '0, 1);
      step(0, '0, '0, '0, 1);
      step(1, W'(100), W'(101), W'(102), 1);
      checks++;
      if (LEVEL !== 3'd4 || OVF !== 1'b0) begin
         errs++;
         $display("FAIL full_pop: level=%0d ovf=%b want 4 0", LEVEL, OVF);
      end
      for (int i = 0; i < 14; i++) step(0, '0, '0, '0, 1);
      checks++;
      if (got.size() != 15 || got[12] !== W'(100) || got[14] !== W'(102)) begin
         errs++;
         $display("FAIL full_pop_data: got %p", got);
      end
   endtask

   task automatic test_wrap();
      logic [W-1:0] w;
      do_reset();
      for (int k = 0; k < 10; k++) begin
         step(1, W'(3*k+1), W'(3*k+2), W'(3*k+3), 1);
         step(0, '0, '0, '0, 1);
         step(0, '0, '0, '0, 1);
      end
      for (int i = 0; i < 3; i++) step(0, '0, '0, '0, 1);
      checks++;
      if (got.size() != 30 || OVF !== 1'b0) begin
         errs++;
         $display("FAIL wrap_count: got %0d ovf=%b want 30 0", got.size(), OVF);
      end
      for (int i = 0; i < 30 && i < got.size(); i++) begin
         w = W'(i + 1);
         checks++;
         if (got[i] !== w) begin
            errs++;
            $display("FAIL wrap_word%0d: got %0d want %0d", i, got[i], w);
         end
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 400; n++) begin
         step($urandom_range(0, 2) == 0, W'($urandom), W'($urandom),
              W'($urandom), $urandom_range(0, 3) != 0);
         checks++;
         if (DOUT !== m_dout() || VOUT !== (mq.size() > 0) ||
             LEVEL !== 3'(mq.size()) || OVF !== movf) begin
            errs++;
            $display("FAIL rand_cyc%0d: dout=%0d vout=%b level=%0d ovf=%b want %0d %b %0d %b",
                     n, DOUT, VOUT, LEVEL, OVF, m_dout(), mq.size() > 0, mq.size(), movf);
         end
      end
      checks++;
      if (got != mexp) begin
         errs++;
         $display("FAIL rand_stream: got %0d words want %0d", got.size(), mexp.size());
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      step(1, W'(21), W'(22), W'(23), 1);
      step(0, '0, '0, '0, 1);
      checks++;
      if (DOUT !== W'(22)) begin
         errs++;
         $display("FAIL midrst_pre: dout=%0d want 22", DOUT);
      end
      READY = 1'b0;
      #2 RST_n = 1'b0;
      #1;
      checks++;
      if (VOUT !== 1'b0 || DOUT !== '0 || LEVEL !== 3'd0) begin
         errs++;
         $display("FAIL midrst_async: vout=%b dout=%0d level=%0d want 0 0 0", VOUT, DOUT, LEVEL);
      end
      @(posedge CLK);
      #1;
      RST_n = 1'b1;
      m_clear();
      step(1, W'(31), W'(32), W'(33), 1);
      checks++;
      if (VOUT !== 1'b1 || DOUT !== W'(31) || LEVEL !== 3'd1) begin
         errs++;
         $display("FAIL midrst_next: vout=%b dout=%0d level=%0d want 1 31 1", VOUT, DOUT, LEVEL);
      end
   endtask

   initial begin
      VIN = 0; READY = 0; DIN3k = '0; DIN3k1 = '0; DIN3k2 = '0;
      RST_n = 0;
      m_clear();
      test_reset();
      test_single();
      test_backpressure();
      test_overflow();
      test_full_pop();
      test_wrap();
      test_random();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/par3_to_ser.md
PAR3_TO_SER -- requirements
Module: par3_to_ser

Interface
REQ-001 The block SHALL have parameter WIDTH, default 11, sample width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, FIFO depth in triples; a power of two, at least 2.
REQ-003 Port CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port RST_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-005 Port VIN  input  1  SHALL mark DIN3k/DIN3k1/DIN3k2 as a valid triple this cycle.
REQ-006 Ports DIN3k, DIN3k1, DIN3k2  input  WIDTH each  SHALL carry samples 3k, 3k+1, 3k+2 (signed, two's complement).
REQ-007 Port READY  input  1  SHALL indicate that downstream accepts DOUT this cycle.
REQ-008 Port DOUT  output  WIDTH  SHALL carry the current serial sample.
REQ-009 Port VOUT  output  1  SHALL indicate that DOUT is valid.
REQ-010 Port LEVEL  output  log2(DEPTH)+1  SHALL give the number of triples stored, including a partially sent head.
REQ-011 Port OVF  output  1  SHALL be a sticky flag: at least one triple was dropped.

Function
REQ-012 Storage SHALL be a circular FIFO of DEPTH entries, each holding one triple (3*WIDTH bits), with read and write pointers that wrap modulo DEPTH.
REQ-013 Write: on a rising edge with VIN=1 and space available, the triple SHALL be stored at the write pointer; the write pointer and LEVEL SHALL increment.
REQ-014 Output: VOUT SHALL be 1 exactly when LEVEL>0; DOUT SHALL be the head-entry word selected by a phase counter (0->DIN3k, 1->DIN3k1, 2->DIN3k2).
REQ-015 DOUT SHALL be 0 whenever VOUT=0.
REQ-016 Transfer: a word SHALL transfer on an edge where VOUT=1 and READY=1; the phase SHALL increment 0->1->2.
REQ-017 Pop: a transfer at phase 2 SHALL set the phase to 0, advance the read pointer and decrement LEVEL.
REQ-018 Backpressure: with READY=0, DOUT, VOUT, the phase and the head entry SHALL hold stable.
REQ-019 Latency: a triple written into an empty FIFO at edge t SHALL present DIN3k on DOUT with VOUT=1 in the cycle after edge t; with READY=1 continuously, the three words SHALL appear on three consecutive cycles.
REQ-020 Simultaneous write and pop on the same edge SHALL both take effect, leaving LEVEL unchanged.
REQ-021 Full: when LEVEL=DEPTH and VIN=1, the triple SHALL be accepted only if a pop occurs on the same edge; otherwise it SHALL be dropped, FIFO contents SHALL be unchanged, and OVF SHALL set to 1.
REQ-022 OVF, once set, SHALL remain 1 until reset.
REQ-023 Empty: with LEVEL=0, READY SHALL have no effect and the phase SHALL remain 0.
REQ-024 Sustained input (one triple per cycle) exceeds the output rate of one word per cycle; the resulting drops SHALL be reported only through OVF.

Reset
REQ-025 While RST_n=0, the block SHALL immediately force: LEVEL=0, both pointers=0, phase=0, VOUT=0, DOUT=0, OVF=0.
REQ-026 Reset asserted mid-triple SHALL discard all stored and partially sent data, with no further output of those words.
REQ-027 VIN SHALL be ignored while RST_n=0; normal operation SHALL begin on the first rising edge after RST_n returns to 1.
REQ-028 FIFO data storage SHALL NOT require reset, provided DOUT is masked to 0 while empty.

Verification
REQ-029 Single triple: VIN=1 for one cycle with (5,-3,7), READY=1 -> DOUT is 5, -3, 7 on three consecutive cycles starting one cycle after the write; VOUT then drops; LEVEL goes 1->0; OVF=0.
REQ-030 Backpressure: triple (1,2,3) written, READY=0 for 4 cycles then 1 -> DOUT=1 with VOUT=1 held for those 4 cycles, then 1, 2, 3 emitted; no word is lost or repeated.
REQ-031 Overflow: DEPTH=4, READY=0, VIN=1 for 5 consecutive cycles -> LEVEL=4, OVF=1, fifth triple absent; after READY=1 exactly 12 words (the first four triples) are emitted, and OVF stays 1.
REQ-032 Full plus pop: LEVEL=4, head at phase 2, READY=1 and VIN=1 on the same edge -> new triple accepted, LEVEL stays 4, OVF stays 0.
REQ-033 Pointer wrap: 10 triples with distinct values, VIN every third cycle, READY=1 -> all 30 words emitted in order, OVF=0.
REQ-034 Mid-operation reset: RST_n pulsed low while DOUT shows DIN3k1 of the head triple -> VOUT=0, DOUT=0, LEVEL=0 immediately; after release, the next triple's DIN3k is emitted first.
